// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters plus one registered
// output stage that turns the previous coordinate into sync, blank and colour.
module video_timing_gen #(
  parameter int COLOR_DEPTH = 8,
  parameter int CNT_W       = 12,
  parameter int H_ACTIVE    = 320,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 32,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 240,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 15,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0
) (
  input  logic                   clk_vid,
  input  logic                   reset,
  input  logic                   ce_pix,
  output logic [CNT_W-1:0]       hcount,
  output logic [CNT_W-1:0]       vcount,
  input  logic [COLOR_DEPTH-1:0] R,
  input  logic [COLOR_DEPTH-1:0] G,
  input  logic [COLOR_DEPTH-1:0] B,
  output logic [COLOR_DEPTH-1:0] VGA_R,
  output logic [COLOR_DEPTH-1:0] VGA_G,
  output logic [COLOR_DEPTH-1:0] VGA_B,
  output logic                   HSync,
  output logic                   VSync,
  output logic                   HBlank,
  output logic                   VBlank,
  output logic                   de,
  output logic                   frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(HS_START + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(VS_START + V_SYNC);

  logic [CNT_W-1:0]       hcount_q, hcount_d;
  logic [CNT_W-1:0]       vcount_q, vcount_d;
  logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
  logic                   hsync_q, hblank_q, vblank_q, de_q, fstart_q;
  logic                   vs_active_q, vs_active_d;
  logic                   h_blank, v_blank, hs_act, active;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (ce_pix) begin
      if (hcount_q == H_LAST_C) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST_C) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  // Vertical sync state is sampled only at the hsync leading pixel so its
  // edges land exactly on an HSync leading edge.
  always_comb begin
    h_blank     = (hcount_q >= H_ACT_C);
    v_blank     = (vcount_q >= V_ACT_C);
    hs_act      = (hcount_q >= HS_START_C) && (hcount_q < HS_END_C);
    active      = !h_blank && !v_blank;
    vs_active_d = vs_active_q;
    if (hcount_q == HS_START_C) begin
      vs_active_d = (vcount_q >= VS_START_C) && (vcount_q < VS_END_C);
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hsync_q     <= ~HS_POL;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      de_q        <= 1'b0;
      fstart_q    <= 1'b0;
      vs_active_q <= 1'b0;
    end else if (ce_pix) begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      r_q         <= active ? R : '0;
      g_q         <= active ? G : '0;
      b_q         <= active ? B : '0;
      hsync_q     <= hs_act ? HS_POL : ~HS_POL;
      hblank_q    <= h_blank;
      vblank_q    <= v_blank;
      de_q        <= active;
      fstart_q    <= (hcount_q == '0) && (vcount_q == '0);
      vs_active_q <= vs_active_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign HSync       = hsync_q;
  assign VSync       = vs_active_q ? VS_POL : ~VS_POL;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign de          = de_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a 16x8 raster: a counting model derives every
// output from the number of pixel enables since reset, plus literal spot checks.
module tb_video_timing_gen;

  localparam int CW = 12;
  localparam int HT = 16;
  localparam int VT = 8;

  logic          clk_vid = 1'b0;
  logic          reset;
  logic          ce_pix;
  logic [CW-1:0] hcount, vcount;
  logic [7:0]    r_in, g_in, b_in;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          hsync, vsync, hblank, vblank, de, frame_start;

  int total = 0;
  int bad   = 0;
  int n_ce  = 0;

  video_timing_gen #(
    .COLOR_DEPTH(8), .CNT_W(CW),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
    .hcount(hcount), .vcount(vcount),
    .R(r_in), .G(g_in), .B(b_in),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .HSync(hsync), .VSync(vsync), .HBlank(hblank), .VBlank(vblank),
    .de(de), .frame_start(frame_start)
  );

  always #5 clk_vid = ~clk_vid;

  // Pixel source answers combinationally with its own coordinate.
  assign r_in = hcount[7:0];
  assign g_in = vcount[7:0];
  assign b_in = 8'hAA;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (ce count %0d, t=%0t)", name, act, exp, n_ce, $time);
    end
  endtask

  always @(posedge clk_vid or posedge reset) begin
    if (reset) n_ce = 0;
    else if (ce_pix) n_ce = n_ce + 1;
  end

  // Outputs after n enables describe raster position n-1 (linear pixel index).
  always @(negedge clk_vid) begin
    int p, ph, pv, li;
    bit act;
    chk("hcount", hcount, n_ce % HT);
    chk("vcount", vcount, (n_ce / HT) % VT);
    if (n_ce == 0) begin
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 0);
      chk("rst_hblank", hblank, 1);
      chk("rst_vblank", vblank, 1);
      chk("rst_de", de, 0);
      chk("rst_fs", frame_start, 0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    end else begin
      p   = (n_ce - 1) % (HT * VT);
      ph  = p % HT;
      pv  = p / HT;
      li  = p;
      act = (ph < 8) && (pv < 4);
      chk("hblank", hblank, ph >= 8);
      chk("vblank", vblank, pv >= 4);
      chk("hsync", hsync, !(ph >= 10 && ph <= 12));
      chk("vsync", vsync, (li >= 5 * HT + 10) && (li < 7 * HT + 10));
      chk("de", de, act);
      chk("frame_start", frame_start, (ph == 0) && (pv == 0));
      chk("vga_r", vga_r, act ? ph : 0);
      chk("vga_g", vga_g, act ? pv : 0);
      chk("vga_b", vga_b, act ? 8'hAA : 0);
    end
  end

  task automatic tick(input logic ce);
    ce_pix = ce;
    @(posedge clk_vid);
    #1;
  endtask

  task automatic go_to(input int target, input int gap);
    int guard = 0;
    while (n_ce < target && guard < 5000) begin
      repeat (gap) tick(1'b0);
      tick(1'b1);
      guard++;
    end
    ce_pix = 1'b0;
    chk("go_to_reached", n_ce, target);
  endtask

  initial begin
    reset  = 1'b1;
    ce_pix = 1'b0;
    repeat (2) @(posedge clk_vid);
    #1;
    chk("lit_rst_hsync", hsync, 1);
    chk("lit_rst_vsync", vsync, 0);
    reset = 1'b0;

    go_to(1, 0);
    chk("lit_fs_first", frame_start, 1);
    chk("lit_h_after1", hcount, 1);
    chk("lit_vga_b_first", vga_b, 8'hAA);
    go_to(8, 0);   chk("lit_hblank_out7", hblank, 0);
    go_to(9, 0);   chk("lit_hblank_out8", hblank, 1);
    go_to(11, 0);  chk("lit_hsync_out10", hsync, 0);
    go_to(13, 0);  chk("lit_hsync_out12", hsync, 0);
    go_to(14, 0);  chk("lit_hsync_out13", hsync, 1);
    go_to(36, 0);  chk("lit_vga_r_3_2", vga_r, 3); chk("lit_vga_g_3_2", vga_g, 2);
    go_to(64, 0);  chk("lit_vblank_out15_3", vblank, 0);
    go_to(65, 0);  chk("lit_vblank_out0_4", vblank, 1); chk("lit_de_blank", de, 0);
    go_to(90, 0);  chk("lit_vsync_out9_5", vsync, 0);
    go_to(91, 0);  chk("lit_vsync_out10_5", vsync, 1);
    go_to(122, 0); chk("lit_vsync_out9_7", vsync, 1);
    go_to(123, 0); chk("lit_vsync_out10_7", vsync, 0);
    go_to(128, 0); chk("lit_wrap_h", hcount, 0); chk("lit_wrap_v", vcount, 0);
    chk("lit_fs_not_yet", frame_start, 0);
    go_to(129, 0); chk("lit_fs_second", frame_start, 1); chk("lit_vblank_fall", vblank, 0);

    go_to(300, 2); // enable every third clock
    chk("lit_slow_h", hcount, 300 % HT);

    reset = 1'b1;
    @(posedge clk_vid);
    #1;
    reset = 1'b0;
    go_to(38, 0);
    chk("lit_vga_r_5_2", vga_r, 5);
    chk("lit_vga_g_5_2", vga_g, 2);
    reset = 1'b1;
    #2;
    chk("lit_midrst_h", hcount, 0);
    chk("lit_midrst_hblank", hblank, 1);
    chk("lit_midrst_de", de, 0);
    chk("lit_midrst_vga_r", vga_r, 0);
    @(posedge clk_vid);
    #1;
    reset = 1'b0;
    go_to(1, 0);
    chk("lit_fs_after_rst", frame_start, 1);
    chk("lit_de_after_rst", de, 1);
    go_to(200, 0);

    @(negedge clk_vid);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
